// File: rtl/matrix_pkg.sv
// Shared constants, opcodes and sequencer state encoding for the matrix coprocessor.
package matrix_pkg;

  localparam int ELEM_W = 8;
  localparam int ROWS   = 5;
  localparam int ROW_W  = ROWS * ELEM_W;
  localparam int ADDR_W = 3;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_OPP   = 3'd2;
  localparam logic [2:0] OP_SCALE = 3'd3;
  localparam logic [2:0] OP_MAX   = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/matrix_row_sequencer.sv
// Walks one matrix operation row by row: bank read, unit issue, latency wait, write-back.
//
// state   | meaning
// S_IDLE  | waiting for start; illegal op raises err next cycle
// S_READ  | rd_en for current row
// S_ISSUE | bank data on unit_a/unit_b with unit_valid
// S_EXEC  | latency countdown, capture unit_result on last cycle
// S_WRITE | wr_en for current row, then next row or finish
// S_DONE  | done pulse, back to idle
module matrix_row_sequencer
  import matrix_pkg::*;
#(
  parameter int UNIT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [ROW_W-1:0]  rd_a,
  input  logic [ROW_W-1:0]  rd_b,
  output logic [2:0]        unit_op,
  output logic [ROW_W-1:0]  unit_a,
  output logic [ROW_W-1:0]  unit_b,
  output logic              unit_valid,
  input  logic [ROW_W-1:0]  unit_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ROW_W-1:0]  wr_data
);

  localparam int LAT_W = $clog2(UNIT_LAT + 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   row;
  logic [LAT_W-1:0]    lat;
  logic [2:0]          op_q;
  logic [ROW_W-1:0]    a_q, b_q, wr_data_q;
  logic                err_q;
  logic                last_lat;

  assign last_lat = (lat == LAT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= '0;
      lat       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && start && (op > OP_MAX);
      case (state)
        S_IDLE: begin
          if (start && (op <= OP_MAX)) begin
            op_q <= op;
            row  <= '0;
          end
        end
        S_ISSUE: begin
          a_q <= rd_a;
          b_q <= rd_b;
          lat <= LAT_W'(UNIT_LAT);
        end
        S_EXEC: begin
          lat <= lat - LAT_W'(1);
          if (last_lat) wr_data_q <= unit_result;
        end
        S_WRITE: begin
          if (row != ADDR_W'(ROWS - 1)) row <= row + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start && (op <= OP_MAX)) state_n = S_READ;
      S_READ:  state_n = S_ISSUE;
      S_ISSUE: state_n = S_EXEC;
      S_EXEC:  if (last_lat) state_n = S_WRITE;
      S_WRITE: state_n = (row == ADDR_W'(ROWS - 1)) ? S_DONE : S_READ;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operands reach the unit straight from the bank in ISSUE and are held afterwards.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    unit_valid = 1'b0;
    unit_a     = a_q;
    unit_b     = b_q;
    wr_en      = 1'b0;
    wr_addr    = '0;
    case (state)
      S_READ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = row;
      end
      S_ISSUE: begin
        busy       = 1'b1;
        unit_valid = 1'b1;
        unit_a     = rd_a;
        unit_b     = rd_b;
      end
      S_EXEC: busy = 1'b1;
      S_WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = row;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    if (op_q == OP_OPP) unit_b = '0;
  end

  assign unit_op = op_q;
  assign wr_data = wr_data_q;
  assign err     = err_q;

endmodule
